// File: rtl/serial_comparator_lsb.sv
// -----------------------------------------------------------------------------
// serial_comparator_lsb
// Bit-serial 16-bit magnitude comparator. Operands are processed LSB-first,
// one bit pair per clock, so a later (more significant) differing bit always
// overrides whatever the lower bits or the cascade seed decided.
//
// Ports
//   clk                 : single clock, rising edge
//   rst                 : synchronous, active-high reset (priority over start)
//   start               : request a comparison; accepted in IDLE or DONE
//   a, b                : 16-bit operands, captured on the accept edge
//   gt_in, lt_in, eq_in : cascade result from the less-significant word,
//                         captured on the accept edge (priority gt > lt > eq)
//   busy                : high while bits are being processed (RUN)
//   done                : one-cycle pulse, result valid (DONE)
//   gt, lt, eq          : registered one-hot result, held until next DONE
// -----------------------------------------------------------------------------
module serial_comparator_lsb (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        gt_in,
   input  logic        lt_in,
   input  logic        eq_in,
   output logic        busy,
   output logic        done,
   output logic        gt,
   output logic        lt,
   output logic        eq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Running result encoding: {gt, lt, eq}
   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_LT = 3'b010;
   localparam logic [2:0] RES_EQ = 3'b001;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [15:0] a_sh_r;
   logic [15:0] b_sh_r;
   logic [2:0]  run_r;
   logic [2:0]  step_s;
   logic        accept_s;

   // Resolve the cascade inputs into a one-hot seed. Malformed inputs fall
   // through the priority chain; eq_in and the all-zero case both mean equal.
   function automatic logic [2:0] seed_result(input logic g_i,
                                              input logic l_i,
                                              input logic e_i);
      logic [2:0] res;
      if (g_i) begin
         res = RES_GT;
      end else if (l_i) begin
         res = RES_LT;
      end else if (e_i) begin
         res = RES_EQ;
      end else begin
         res = RES_EQ;
      end
      return res;
   endfunction

   // One LSB-first step: a differing bit replaces the running result,
   // equal bits leave it alone.
   function automatic logic [2:0] step_result(input logic [2:0] run_i,
                                              input logic       a_bit,
                                              input logic       b_bit);
      logic [2:0] res;
      case ({a_bit, b_bit})
         2'b10:   res = RES_GT;
         2'b01:   res = RES_LT;
         default: res = run_i;
      endcase
      return res;
   endfunction

   // Start is honoured only outside RUN; a start during RUN is simply dropped.
   always_comb begin
      accept_s = 1'b0;
      if (start && (state_r != ST_RUN)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Result of processing the current bit pair.
   always_comb begin
      step_s = step_result(run_r, a_sh_r[0], b_sh_r[0]);
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         a_sh_r  <= 16'd0;
         b_sh_r  <= 16'd0;
         run_r   <= RES_EQ;
         busy    <= 1'b0;
         done    <= 1'b0;
         gt      <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b1;
      end else if (accept_s) begin
         state_r <= ST_RUN;
         cnt_r   <= 4'd0;
         a_sh_r  <= a;
         b_sh_r  <= b;
         run_r   <= seed_result(gt_in, lt_in, eq_in);
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            ST_RUN: begin
               run_r  <= step_s;
               a_sh_r <= {1'b0, a_sh_r[15:1]};
               b_sh_r <= {1'b0, b_sh_r[15:1]};
               cnt_r  <= cnt_r + 4'd1;
               if (cnt_r == 4'd15) begin
                  // Last bit: publish the result including bit 15.
                  state_r <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  gt      <= step_s[2];
                  lt      <= step_s[1];
                  eq      <= step_s[0];
               end else begin
                  busy <= 1'b1;
                  done <= 1'b0;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_comparator_lsb.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator_lsb
// Scoreboard bench: an expected result is queued whenever a comparison is
// accepted and popped by the monitor on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_comparator_lsb;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        gt_in;
   logic        lt_in;
   logic        eq_in;
   logic        busy;
   logic        done;
   logic        gt;
   logic        lt;
   logic        eq;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          last_done_cyc = 0;
   int          prev_done_cyc = 0;
   logic [2:0]  held_res = 3'b001;
   logic [2:0]  sb_q[$];

   serial_comparator_lsb dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .gt_in (gt_in),
      .lt_in (lt_in),
      .eq_in (eq_in),
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .lt    (lt),
      .eq    (eq)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk_val(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   // Reference model: plain magnitude compare, cascade only breaks a tie.
   function automatic logic [2:0] model(input logic [15:0] av,
                                        input logic [15:0] bv,
                                        input logic g_i, input logic l_i);
      if (av > bv)      return 3'b100;
      else if (av < bv) return 3'b010;
      else if (g_i)     return 3'b100;
      else if (l_i)     return 3'b010;
      else              return 3'b001;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   initial forever begin
      @(negedge clk);
      if (done) begin
         done_cnt++;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         if (sb_q.size() == 0) begin
            chk_val("spurious_done", 32'd1, 32'd0);
         end else begin
            logic [2:0] e;
            e = sb_q.pop_front();
            chk_val("result", {29'd0, gt, lt, eq}, {29'd0, e});
            held_res = e;
         end
      end
   end

   // Drive start for one edge, queue expectation, then scramble the inputs.
   // Returns at the negedge of RUN cycle 1.
   task automatic accept(input logic [15:0] av, input logic [15:0] bv,
                         input logic g_i, input logic l_i, input logic e_i);
      @(negedge clk);
      a = av; b = bv; gt_in = g_i; lt_in = l_i; eq_in = e_i;
      start = 1'b1;
      sb_q.push_back(model(av, bv, g_i, l_i));
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      gt_in = 1'($urandom); lt_in = 1'($urandom); eq_in = 1'($urandom);
   endtask

   // From the current negedge, expect n_busy busy cycles then done.
   task automatic wait_done(input int n_busy);
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         if (busy !== 1'b1) break;
         if (n == 0) chk_val("hold_in_run", {29'd0, gt, lt, eq},
                             {29'd0, held_res});
         n++;
         @(negedge clk);
      end
      chk_val("busy_cycles", n, n_busy);
      chk_val("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic g_i, input logic l_i, input logic e_i);
      accept(av, bv, g_i, l_i, e_i);
      wait_done(16);
   endtask

   initial begin
      int dc;
      rst = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
      gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("rst_busy", {31'd0, busy}, 32'd0);
      chk_val("rst_done", {31'd0, done}, 32'd0);
      chk_val("rst_res", {29'd0, gt, lt, eq}, 32'd1);
      rst = 1'b0;

      // Directed cases
      run_op(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
      run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
      run_op(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
      run_op(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_op(16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b1);
      run_op(16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);

      // Start during RUN is ignored
      dc = done_cnt;
      accept(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(11);
      repeat (20) @(negedge clk);
      chk_val("ignored_start_dones", done_cnt - dc, 32'd1);

      // Reset in RUN cycle 8 aborts
      accept(16'h9000, 16'h0001, 1'b0, 1'b0, 1'b1);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      held_res = 3'b001;
      chk_val("abort_busy", {31'd0, busy}, 32'd0);
      chk_val("abort_done", {31'd0, done}, 32'd0);
      chk_val("abort_res", {29'd0, gt, lt, eq}, 32'd1);
      dc = done_cnt;
      repeat (30) @(negedge clk);
      chk_val("abort_no_done", done_cnt - dc, 32'd0);
      run_op(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);

      // Back-to-back: start held in the DONE cycle
      run_op(16'h4000, 16'h3FFF, 1'b0, 1'b0, 1'b1);
      a = 16'h0007; b = 16'h0700; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
      start = 1'b1;
      sb_q.push_back(model(16'h0007, 16'h0700, 1'b0, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk_val("b2b_busy", {31'd0, busy}, 32'd1);
      wait_done(16);
      chk_val("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd17);

      // Random operands, including frequent ties
      for (int i = 0; i < 10; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = (i % 3 == 0) ? ra : 16'($urandom);
         run_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      chk_val("sb_drain", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_comparator_lsb.md
SERIAL_COMPARATOR_LSB -- requirements
Module: serial_comparator_lsb

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a comparison; sampled every edge.
REQ-005 a  input  16  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  16  operand B; sampled only on the edge that accepts start.
REQ-007 gt_in, lt_in, eq_in  input  1 each  cascade result from the less-significant word; sampled only on the accept edge.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 gt, lt, eq  output  1 each  registered final result (A>B, A<B, A==B), one-hot.

Function
REQ-011 FSM states: IDLE, RUN, DONE; 4-bit bit counter; two 16-bit right-shift registers; 3-bit running result register.
REQ-012 Accept: start=1 in IDLE or DONE -> load shift regs with a, b; clear counter; go to RUN.
REQ-013 start=1 in RUN is ignored; it is not queued and has no effect on the result.
REQ-014 Seed on accept: running result from cascade inputs, priority gt_in > lt_in > else eq; non-one-hot or all-zero cascade inputs resolve by this priority (all-zero -> eq).
REQ-015 Each RUN edge processes LSB pair (a_sh[0], b_sh[0]): 1/0 -> running=gt; 0/1 -> running=lt; equal bits -> running unchanged; then both shift right by 1 and counter increments.
REQ-016 Processing is LSB-first; a differing higher bit always overrides lower bits and cascade seed.
REQ-017 On the RUN edge with counter==15, after processing bit 15, go to DONE and copy running result to gt/lt/eq.
REQ-018 Latency: done is high in the cycle immediately after the 16th edge following the accept edge; exactly 16 RUN cycles.
REQ-019 busy=1 exactly while the state is RUN; done=1 exactly while the state is DONE.
REQ-020 DONE lasts one cycle; next state is IDLE, or RUN if start=1 in that cycle (back-to-back, no idle gap).
REQ-021 gt/lt/eq hold their last value from DONE until the next DONE; they do not change during RUN.
REQ-022 gt, lt, eq are always exactly one-hot.
REQ-023 Operand or cascade input changes after the accept edge do not affect the result.

Reset
REQ-024 rst=1 on an edge: state=IDLE, busy=0, done=0, gt=0, lt=0, eq=1, counter=0, shift regs=0; rst has priority over start.
REQ-025 rst during RUN aborts the comparison; no done pulse is produced for the aborted operation.
REQ-026 The first start after rst deasserts is accepted normally.

Verification
REQ-027 a=0x8000, b=0x7FFF, eq_in=1 -> busy for 16 cycles, then a single done with gt=1, lt=0, eq=0.
REQ-028 a=b=0x1234, gt_in=1 -> gt=1 (cascade propagates); repeat with lt_in=1 -> lt=1; repeat with all cascade inputs 0 -> eq=1.
REQ-029 a=0x0001, b=0x0000, lt_in=1 -> gt=1 (bit overrides seed); a=0x00F0, b=0x0F00 -> lt=1 (higher bit overrides lower).
REQ-030 Pulse start again on RUN cycle 5 with a=0xFFFF, b=0 -> exactly one done, with the result of the first operands only.
REQ-031 rst on RUN cycle 8 -> next cycle busy=0, done=0, gt/lt/eq=0/0/1; no done afterward; a fresh start completes correctly.
REQ-032 start held high in the DONE cycle with new operands -> busy=1 on the next cycle; second done exactly 17 cycles after the first.
